difftest_deferred_control: RTL and testbench

- Batches per-cycle difftest commit-step counts and issues them as deferred "step N" requests to an external checker.
- Returns the checker's verdict as an 8-bit `simv_result` code to the simulation endpoint.
- Sits between the DUT's `difftest_step` output and the checker interface. The endpoint reads `simv_result` for fail/goodtrap/exceed/warmup handling.

---
 rtl/difftest_deferred_control_if.sv | 21 ++
 rtl/difftest_deferred_control.sv | 131 +++++++++++++
 tb/tb_difftest_deferred_control.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/difftest_deferred_control_if.sv
// Checker-side handshake bundle: deferred step requests out, verdicts back.
// master = the batching controller, slave = the external checker.
interface difftest_deferred_control_if #(
    parameter int ACC_W = 32
);
    logic             req_valid;
    logic [ACC_W-1:0] req_nstep;
    logic             req_ready;
    logic             rsp_valid;
    logic [7:0]       rsp_result;

    modport master (
        output req_valid, req_nstep,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_nstep,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/difftest_deferred_control.sv
// Batches commit-step counts into deferred "step N" checker requests and returns the verdict.
// Optional partial-batch idle timeout is enabled with `define DEFERRED_TIMEOUT_EN.
module difftest_deferred_control #(
    parameter int STEP_W      = 8,
    parameter int ACC_W       = 32,
    parameter int BATCH_STEPS = 64,
    parameter int IDLE_CYCLES = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [STEP_W-1:0]           step,
    input  logic                        flush,
    difftest_deferred_control_if.master chk,
    output logic [7:0]                  simv_result
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] BATCH_L = ACC_W'(BATCH_STEPS);
    localparam logic [7:0]       CODE_FAIL = 8'd3;

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic             req_valid_reg, req_valid_next;
    logic [ACC_W-1:0] req_nstep_reg, req_nstep_next;
    logic [7:0]       simv_reg, simv_next;
    logic             fail_reg, fail_next;
    logic             issue;
    logic             timeout;

    // Saturating acc + step; this is the value a request would carry this cycle.
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_sum;
    assign sum_wide = {1'b0, acc_reg} + {{(ACC_W + 1 - STEP_W){1'b0}}, step};
    assign acc_sum  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

`ifdef DEFERRED_TIMEOUT_EN
    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] IDLE_L = CNT_W'(IDLE_CYCLES);

    logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;

    assign timeout = (state_reg == IDLE) && (acc_reg != '0) &&
                     ((idle_cnt_reg + 1'b1) == IDLE_L);

    // Counter holds at its limit while requests are suppressed after a FAIL.
    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if ((state_reg != IDLE) || (acc_reg == '0) || issue) begin
            idle_cnt_next = '0;
        end else if (!timeout) begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        req_valid_next = req_valid_reg;
        req_nstep_next = req_nstep_reg;
        fail_next      = fail_reg;
        simv_next      = fail_reg ? CODE_FAIL : 8'd0;
        issue          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fail_reg && ((acc_sum >= BATCH_L) ||
                                  (flush && (acc_sum != '0)) || timeout)) begin
                    issue          = 1'b1;
                    state_next     = REQ;
                    req_valid_next = 1'b1;
                    req_nstep_next = acc_sum;
                end
            end
            REQ: begin
                if (chk.req_ready) begin
                    req_valid_next = 1'b0;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (chk.rsp_valid) begin
                    state_next = IDLE;
                    simv_next  = chk.rsp_result;
                    if (chk.rsp_result == CODE_FAIL) begin
                        fail_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Steps of the issue cycle travel with the request, so the batch restarts at zero.
        acc_next = issue ? '0 : acc_sum;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            req_valid_reg <= 1'b0;
            req_nstep_reg <= '0;
            simv_reg      <= 8'd0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            req_valid_reg <= req_valid_next;
            req_nstep_reg <= req_nstep_next;
            simv_reg      <= simv_next;
            fail_reg      <= fail_next;
        end
    end

    assign chk.req_valid = req_valid_reg;
    assign chk.req_nstep = req_nstep_reg;
    assign simv_result   = simv_reg;
endmodule

// File: tb/tb_difftest_deferred_control.sv
// Directed bench: expected request step counts are queued at stimulus time and
// popped by a monitor on every accepted request; verdict timing checked inline.
module tb_difftest_deferred_control;
    localparam int ACC_W = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] step  = 8'd0;
    logic       flush = 1'b0;
    logic [7:0] simv_result;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    difftest_deferred_control_if #(.ACC_W(ACC_W)) bus ();

    difftest_deferred_control #(
        .STEP_W(8), .ACC_W(ACC_W), .BATCH_STEPS(64), .IDLE_CYCLES(16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .step        (step),
        .flush       (flush),
        .chk         (bus.master),
        .simv_result (simv_result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every accepted request must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && bus.req_valid && bus.req_ready) begin
            if (exp_q.size() == 0) begin
                check("req_unexpected", {31'b0, bus.req_valid}, 32'd0);
            end else begin
                logic [31:0] exp_n;
                exp_n = exp_q.pop_front();
                check("req_nstep", bus.req_nstep, exp_n);
                $display("request accepted: nstep=%0d expected=%0d", bus.req_nstep, exp_n);
            end
        end
    end

    // Waits (bounded) for req_valid with req_ready=1, then lets the handshake edge pass.
    task automatic wait_req();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.req_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("req_arrival", {31'b0, found}, 32'd1);
        tick();
        check("req_drop", {31'b0, bus.req_valid}, 32'd0);
    endtask

    task automatic respond(input logic [7:0] code, input logic [7:0] stp);
        bus.rsp_valid  = 1'b1;
        bus.rsp_result = code;
        step           = stp;
        tick();
        bus.rsp_valid  = 1'b0;
        step           = 8'd0;
        check("simv_result", {24'b0, simv_result}, {24'b0, code});
        $display("verdict %0d -> simv_result=%0d", code, simv_result);
        if (code != 8'd0 && code != 8'd3) begin
            tick();
            check("simv_clear", {24'b0, simv_result}, 32'd0);
        end
    endtask

    initial begin
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_result = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_req_valid", {31'b0, bus.req_valid}, 32'd0);
        check("reset_req_nstep", bus.req_nstep, 32'd0);
        check("reset_simv", {24'b0, simv_result}, 32'd0);

        // Threshold batch: 8 x 8 = 64
        bus.req_ready = 1'b1;
        exp_q.push_back(32'd64);
        for (int i = 0; i < 8; i++) begin
            step = 8'd8;
            tick();
        end
        step = 8'd0;
        wait_req();
        respond(8'd1, 8'd0);

        // Flush partial: 5 x 3 + 2 in the flush cycle
        exp_q.push_back(32'd17);
        for (int i = 0; i < 5; i++) begin
            step = 8'd3;
            tick();
        end
        step  = 8'd2;
        flush = 1'b1;
        tick();
        step  = 8'd0;
        flush = 1'b0;
        wait_req();
        respond(8'd4, 8'd0);

        // Flush with an empty accumulator issues nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("empty_flush", {31'b0, bus.req_valid}, 32'd0);

        // Backpressure: request held stable while steps keep accumulating
        bus.req_ready = 1'b0;
        exp_q.push_back(32'd64);
        step = 8'd64;
        tick();
        step = 8'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_nstep", bus.req_nstep, 32'd64);
            check("bp_valid", {31'b0, bus.req_valid}, 32'd1);
        end
        step = 8'd0;
        bus.req_ready = 1'b1;
        wait_req();
        exp_q.push_back(32'd11);
        respond(8'd2, 8'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_req();
        respond(8'd0, 8'd0);

        // Unknown verdict code passes through as a pulse
        exp_q.push_back(32'd64);
        step = 8'd64;
        tick();
        step = 8'd0;
        wait_req();
        respond(8'd7, 8'd0);

        // FAIL is sticky and suppresses further requests
        exp_q.push_back(32'd64);
        step = 8'd64;
        tick();
        step = 8'd0;
        wait_req();
        respond(8'd3, 8'd0);
        step = 8'd64;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("fail_hold", {24'b0, simv_result}, 32'd3);
            check("fail_no_req", {31'b0, bus.req_valid}, 32'd0);
        end
        step  = 8'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post_reset_simv", {24'b0, simv_result}, 32'd0);
        check("post_reset_req", {31'b0, bus.req_valid}, 32'd0);

        // Stale verdict in IDLE is ignored
        bus.rsp_valid  = 1'b1;
        bus.rsp_result = 8'd1;
        tick();
        bus.rsp_valid  = 1'b0;
        check("stale_rsp", {24'b0, simv_result}, 32'd0);
        tick();
        check("stale_rsp_late", {24'b0, simv_result}, 32'd0);

        // Accumulator cleared by reset
        exp_q.push_back(32'd1);
        step  = 8'd1;
        flush = 1'b1;
        tick();
        step  = 8'd0;
        flush = 1'b0;
        wait_req();
        respond(8'd1, 8'd0);

        // Reset abandons an outstanding request
        bus.req_ready = 1'b0;
        step = 8'd64;
        tick();
        step = 8'd0;
        check("pending_req", {31'b0, bus.req_valid}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abandon_valid", {31'b0, bus.req_valid}, 32'd0);
        check("abandon_nstep", bus.req_nstep, 32'd0);
        bus.req_ready = 1'b1;
        tick();
        tick();
        exp_q.push_back(32'd2);
        step  = 8'd2;
        flush = 1'b1;
        tick();
        step  = 8'd0;
        flush = 1'b0;
        wait_req();
        respond(8'd1, 8'd0);

        // Partial batch left idle
        step = 8'd5;
        tick();
        step = 8'd0;
`ifdef DEFERRED_TIMEOUT_EN
        begin
            int n;
            n = 0;
            exp_q.push_back(32'd5);
            for (int i = 0; i < 40; i++) begin
                tick();
                n++;
                if (bus.req_valid) break;
            end
            check("timeout_cycles", n, 32'd16);
            tick();
            respond(8'd1, 8'd0);
        end
`else
        for (int i = 0; i < 40; i++) tick();
        check("no_timeout", {31'b0, bus.req_valid}, 32'd0);
`endif

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
